// File: rtl/i2s_pkg.sv
// Shared constants and helpers for the i2s receive arbiter slice.
package i2s_pkg;

    localparam int BITS_PRECISION_DEF = 24;

    // left_rightn encoding as driven by the i2sin receivers
    localparam logic LEFT  = 1'b1;
    localparam logic RIGHT = 1'b0;

    function automatic int ch_idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/i2s_rx_arbiter_rr_arbiter.sv
// Round-robin arbiter: grants the first request at or above the pointer,
// wrapping modulo N; the pointer moves past the winner on an advance strobe.
module rr_arbiter #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant,
    output logic [W-1:0] grant_idx,
    output logic         grant_any
);

    logic [W-1:0] ptr_r;

    // Rotating priority search starting at ptr_r
    always_comb begin
        grant     = {N{1'b0}};
        grant_idx = {W{1'b0}};
        grant_any = 1'b0;
        for (int i = 0; i < N; i++) begin
            int j;
            j = int'(ptr_r) + i;
            j = (j >= N) ? (j - N) : j;
            if (!grant_any && req[j]) begin
                grant_any = 1'b1;
                grant[j]  = 1'b1;
                grant_idx = W'(j);
            end else begin
                grant_any = grant_any;
            end
        end
    end

    // Pointer register, moves one past the granted index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r <= {W{1'b0}};
        end else if (advance && grant_any) begin
            ptr_r <= (grant_idx == W'(N - 1)) ? {W{1'b0}} : (grant_idx + W'(1));
        end else begin
            ptr_r <= ptr_r;
        end
    end

endmodule

// File: rtl/i2s_rx_arbiter.sv
// Buffers one left/right sample per i2sin receiver and serialises them onto a
// single valid/ready stream using round-robin over 2*NUM_CH slots.
module i2s_rx_arbiter
    import i2s_pkg::*;
#(
    parameter int NUM_CH         = 4,
    parameter int BITS_PRECISION = BITS_PRECISION_DEF,
    localparam int CH_W          = ch_idx_w(NUM_CH)
) (
    input  logic                             sck,
    input  logic                             rst_n,
    input  logic [NUM_CH*BITS_PRECISION-1:0] ch_data,
    input  logic [NUM_CH-1:0]                ch_left_rightn,
    input  logic [NUM_CH-1:0]                ch_data_en,
    output logic [BITS_PRECISION-1:0]        out_data,
    output logic [CH_W-1:0]                  out_ch,
    output logic                             out_left_rightn,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [NUM_CH-1:0]                overflow,
    input  logic                             ovf_clear
);

    localparam int NS = 2 * NUM_CH;
    localparam int SW = ch_idx_w(NS);

    logic [NS-1:0]             full_r;
    logic [BITS_PRECISION-1:0] slot_data_r [NS];
    logic [NS-1:0]             wr_s;
    logic [NS-1:0]             take_s;
    logic [NUM_CH-1:0]         ovf_set_s;
    logic                      load_s;
    logic [NS-1:0]             gnt_s;
    logic [SW-1:0]             gnt_idx_s;
    logic                      gnt_any_s;

    assign load_s = !out_valid || out_ready;
    assign take_s = gnt_s & {NS{load_s}};

    rr_arbiter #(.N(NS), .W(SW)) u_rr (
        .clk       (sck),
        .rst_n     (rst_n),
        .req       (full_r),
        .advance   (load_s),
        .grant     (gnt_s),
        .grant_idx (gnt_idx_s),
        .grant_any (gnt_any_s)
    );

    // Slot write strobes and overrun detection; a slot emptied on this edge is not an overrun
    always_comb begin
        wr_s      = {NS{1'b0}};
        ovf_set_s = {NUM_CH{1'b0}};
        for (int c = 0; c < NUM_CH; c++) begin
            int s;
            s = 2 * c + int'(ch_left_rightn[c]);
            if (ch_data_en[c]) begin
                wr_s[s]      = 1'b1;
                ovf_set_s[c] = full_r[s] && !take_s[s];
            end else begin
                wr_s[s] = wr_s[s];
            end
        end
    end

    // Slot storage: capture wins over a same-edge grant, so the slot stays full
    always_ff @(posedge sck or negedge rst_n) begin
        if (!rst_n) begin
            full_r <= {NS{1'b0}};
            for (int s = 0; s < NS; s++) begin
                slot_data_r[s] <= {BITS_PRECISION{1'b0}};
            end
        end else begin
            full_r <= (full_r & ~take_s) | wr_s;
            for (int c = 0; c < NUM_CH; c++) begin
                if (ch_data_en[c]) begin
                    slot_data_r[2 * c + int'(ch_left_rightn[c])] <= ch_data[c*BITS_PRECISION +: BITS_PRECISION];
                end
            end
        end
    end

    // Output register, held while the mixer stalls
    always_ff @(posedge sck or negedge rst_n) begin
        if (!rst_n) begin
            out_data        <= {BITS_PRECISION{1'b0}};
            out_ch          <= {CH_W{1'b0}};
            out_left_rightn <= 1'b0;
            out_valid       <= 1'b0;
        end else if (load_s && gnt_any_s) begin
            out_data        <= slot_data_r[gnt_idx_s];
            out_ch          <= CH_W'(gnt_idx_s >> 1);
            out_left_rightn <= gnt_idx_s[0];
            out_valid       <= 1'b1;
        end else if (load_s) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= out_valid;
        end
    end

    // Sticky overrun flags; a new overrun beats a coincident clear
    always_ff @(posedge sck or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= {NUM_CH{1'b0}};
        end else begin
            overflow <= (overflow & ~{NUM_CH{ovf_clear}}) | ovf_set_s;
        end
    end

endmodule
